// File: rtl/fnd_scan_ctrl.sv
// Multiplexed scan controller for a 4-digit common-anode FND.
// Source, digits, dp mask and blanking mode are latched at frame boundaries so a frame never tears.
module fnd_scan_ctrl #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned SCAN_HZ   = 1000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_sel_src,
  input  logic [15:0] i_watch_bcd,
  input  logic [15:0] i_sw_bcd,
  input  logic [3:0]  i_dot_mask,
  input  logic        i_lzb_en,
  output logic [3:0]  o_fnd_com,
  output logic [7:0]  o_fnd_data,
  output logic        o_frame_start
);

  localparam int unsigned DIV    = CLK_FREQ / SCAN_HZ;
  localparam int unsigned CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned BCD_W  = 16;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned DATA_W = 8;

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    div_cnt, div_nxt;
  logic [IDX_W-1:0]    idx;
  logic                slot_end;
  logic                frame_end;

  logic [BCD_W-1:0]    lat_bcd;
  logic [DIGITS-1:0]   lat_dot;
  logic                lat_lzb;

  logic [NIB_W-1:0]    cur_nib;
  logic [DIGITS-1:0]   lz_blank;
  logic [SEG_W-1:0]    cur_seg;
  logic [DIGITS-1:0]   com_d;
  logic [DATA_W-1:0]   data_d;

  // Active-low 7-segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles show a dash.
  function automatic logic [SEG_W-1:0] seg7(input logic [NIB_W-1:0] nib);
    case (nib)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h3F;
    endcase
  endfunction

  assign slot_end  = (div_cnt == DIV_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign div_nxt   = slot_end ? '0 : div_cnt + CNT_W'(1);

  // Slot divider and digit index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      idx     <= '0;
    end else begin
      div_cnt <= div_nxt;
      if (slot_end) idx <= idx + IDX_W'(1);
    end
  end

  // Frame-boundary capture of everything that affects what is displayed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_bcd       <= '0;
      lat_dot       <= '0;
      lat_lzb       <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      o_frame_start <= frame_end;
      if (frame_end) begin
        lat_bcd <= i_sel_src ? i_sw_bcd : i_watch_bcd;
        lat_dot <= i_dot_mask;
        lat_lzb <= i_lzb_en;
      end
    end
  end

  // A digit is a leading zero when it and every more significant digit are zero
  always_comb begin
    lz_blank    = '0;
    lz_blank[3] = (lat_bcd[15:12] == 4'd0);
    lz_blank[2] = lz_blank[3] && (lat_bcd[11:8] == 4'd0);
    lz_blank[1] = lz_blank[2] && (lat_bcd[7:4] == 4'd0);
  end

  assign cur_nib = lat_bcd[{idx, 2'b00} +: NIB_W];
  assign cur_seg = (lat_lzb && lz_blank[idx]) ? 7'h7F : seg7(cur_nib);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_BLANK;
    else        state_q <= state_d;
  end

  // Next state follows the slot phase; pin values are derived from the current state
  always_comb begin
    state_d = state_q;
    com_d   = '1;
    data_d  = '1;
    if (div_nxt < BLANK_END) state_d = ST_BLANK;
    else                     state_d = ST_SHOW;
    case (state_q)
      ST_SHOW: begin
        com_d  = ~(DIGITS'(1) << idx);
        data_d = {~lat_dot[idx], cur_seg};
      end
      default: begin
        com_d  = '1;
        data_d = '1;
      end
    endcase
  end

  // Registered pin drivers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_fnd_com  <= '1;
      o_fnd_data <= '1;
    end else begin
      o_fnd_com  <= com_d;
      o_fnd_data <= data_d;
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed bench for fnd_scan_ctrl with DIV = 10 and a 2-clock blank window.
module tb_fnd_scan_ctrl;

  localparam int unsigned CLK_FREQ  = 100;
  localparam int unsigned SCAN_HZ   = 10;
  localparam int unsigned BLANK_CYC = 2;
  localparam int unsigned DIV       = CLK_FREQ / SCAN_HZ;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_sel_src;
  logic [15:0] i_watch_bcd;
  logic [15:0] i_sw_bcd;
  logic [3:0]  i_dot_mask;
  logic        i_lzb_en;
  logic [3:0]  o_fnd_com;
  logic [7:0]  o_fnd_data;
  logic        o_frame_start;

  int n_checks = 0;
  int n_errors = 0;

  fnd_scan_ctrl #(
    .CLK_FREQ (CLK_FREQ),
    .SCAN_HZ  (SCAN_HZ),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_sel_src    (i_sel_src),
    .i_watch_bcd  (i_watch_bcd),
    .i_sw_bcd     (i_sw_bcd),
    .i_dot_mask   (i_dot_mask),
    .i_lzb_en     (i_lzb_en),
    .o_fnd_com    (o_fnd_com),
    .o_fnd_data   (o_fnd_data),
    .o_frame_start(o_frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sel;
    logic [15:0] watch;
    logic [15:0] sw;
    logic [3:0]  dot;
    logic        lzb;
    logic [3:0][7:0] exp;   // expected data byte per digit, [3] = digit3
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Starts right after a boundary edge (div_cnt = 0, idx = 0); ends on the next boundary edge.
  task automatic check_frame(input logic [3:0][7:0] exp, input int toggle_slot, input string tag);
    logic [3:0] ecom;
    for (int k = 0; k < 4; k++) begin
      ecom = ~(4'b0001 << k);
      step(1);
      chk($sformatf("%s d%0d blank com", tag, k), {4'h0, o_fnd_com}, 8'h0F);
      chk($sformatf("%s d%0d blank data", tag, k), o_fnd_data, 8'hFF);
      step(2);
      chk($sformatf("%s d%0d show com", tag, k), {4'h0, o_fnd_com}, {4'h0, ecom});
      chk($sformatf("%s d%0d show data", tag, k), o_fnd_data, exp[k]);
      if (k == toggle_slot) i_sel_src = ~i_sel_src;
      step(7);
      chk($sformatf("%s d%0d end com", tag, k), {4'h0, o_fnd_com}, {4'h0, ecom});
      chk($sformatf("%s d%0d end data", tag, k), o_fnd_data, exp[k]);
    end
    chk($sformatf("%s frame_start", tag), {7'h0, o_frame_start}, 8'h01);
  endtask

  task automatic wait_frame(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < int'(8 * DIV); i++) begin
      step(1);
      if (o_frame_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk($sformatf("%s frame wait", tag), {7'h0, seen}, 8'h01);
  endtask

  task automatic apply(input vec_t v);
    i_sel_src   = v.sel;
    i_watch_bcd = v.watch;
    i_sw_bcd    = v.sw;
    i_dot_mask  = v.dot;
    i_lzb_en    = v.lzb;
  endtask

  initial begin
    vecs[0] = '{"w1234",   1'b0, 16'h1234, 16'h5678, 4'b0000, 1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
    vecs[1] = '{"s5678",   1'b1, 16'h1234, 16'h5678, 4'b0000, 1'b0, {8'h92, 8'h82, 8'hF8, 8'h80}};
    vecs[2] = '{"lzb0050", 1'b0, 16'h0050, 16'h9999, 4'b1000, 1'b1, {8'h7F, 8'hFF, 8'h92, 8'hC0}};
    vecs[3] = '{"nolzb",   1'b0, 16'h0050, 16'h9999, 4'b1000, 1'b0, {8'h40, 8'hC0, 8'h92, 8'hC0}};
    vecs[4] = '{"oorFC07", 1'b0, 16'hFC07, 16'h0000, 4'b0101, 1'b1, {8'hBF, 8'h3F, 8'hC0, 8'h78}};
    vecs[5] = '{"lzb0000", 1'b0, 16'h0000, 16'h1111, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
    vecs[6] = '{"lzb0100", 1'b1, 16'h8888, 16'h0100, 4'b0000, 1'b1, {8'hFF, 8'hF9, 8'hC0, 8'hC0}};
    vecs[7] = '{"oorA0B9", 1'b1, 16'h0000, 16'hA0B9, 4'b0000, 1'b0, {8'hBF, 8'hC0, 8'hBF, 8'h90}};

    reset = 1'b1;
    apply(vecs[0]);
    #1 reset = 1'b0;

    // Reset values, then the reset-latched "0000" frame and first boundary pulse
    step(3);
    chk("rst com", {4'h0, o_fnd_com}, 8'h0F);
    chk("rst data", o_fnd_data, 8'hFF);
    chk("rst frame_start", {7'h0, o_frame_start}, 8'h00);
    reset = 1'b1;
    check_frame({8'hC0, 8'hC0, 8'hC0, 8'hC0}, -1, "post_rst");
    step(1);
    chk("frame_start width", {7'h0, o_frame_start}, 8'h00);

    for (int v = 0; v < 8; v++) begin
      apply(vecs[v]);
      wait_frame(vecs[v].name);
      check_frame(vecs[v].exp, -1, vecs[v].name);
    end

    // Source switch during idx = 1 must not disturb the frame in progress
    apply(vecs[0]);
    wait_frame("atomic");
    check_frame(vecs[0].exp, 1, "atomic_cur");
    check_frame(vecs[1].exp, -1, "atomic_next");

    // Asynchronous reset during SHOW of digit 2
    apply(vecs[0]);
    i_lzb_en = 1'b1;
    wait_frame("midrst");
    step(23);
    chk("midrst pre com", {4'h0, o_fnd_com}, 8'h0B);
    #2 reset = 1'b0;
    #1;
    chk("midrst async com", {4'h0, o_fnd_com}, 8'h0F);
    chk("midrst async data", o_fnd_data, 8'hFF);
    step(2);
    chk("midrst held com", {4'h0, o_fnd_com}, 8'h0F);
    reset = 1'b1;
    check_frame({8'hC0, 8'hC0, 8'hC0, 8'hC0}, -1, "midrst_after");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fnd_scan_ctrl.md
Name: fnd_scan_ctrl

Overview:
- Scan controller for the 4-digit common-anode FND on the watch board.
- Sequences the digit-select counter on a divided scan tick and inserts an anti-ghosting blank window at the start of every digit slot.
- Chooses between the watch and stopwatch BCD sources. The source and data are captured only at frame boundaries, so a frame never mixes sources or tears mid-scan.
- Drives the anode and segment pins directly.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- SCAN_HZ, 1000, digit-slot rate in Hz. DIV = CLK_FREQ/SCAN_HZ clocks per slot; DIV must be at least BLANK_CYC+2.
- BLANK_CYC, 16, clocks at the start of each slot with all anodes off; must be at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_sel_src  in  1  source select: 0 = watch, 1 = stopwatch.
- i_watch_bcd  in  16  watch digits; [3:0] is digit0 (least significant) through [15:12] is digit3.
- i_sw_bcd  in  16  stopwatch digits, same packing.
- i_dot_mask  in  4  bit k = 1 lights the decimal point of digit k.
- i_lzb_en  in  1  leading-zero blanking enable.
- o_fnd_com  out  4  anode enables, active-low, bit k = digit k.
- o_fnd_data  out  8  segments, active-low: [6:0] = g..a, [7] = dp.
- o_frame_start  out  1  one-clock pulse at the start of each frame.

Behaviour:
- Reset (reset = 0, asynchronous):
  - o_fnd_com = 4'hF, o_fnd_data = 8'hFF, o_frame_start = 0.
  - div_cnt = 0, digit idx = 0, state = BLANK.
  - Latched source = 0, latched BCD = 16'h0000, latched dot mask = 0, latched lzb = 0.
- div_cnt:
  - Counts 0..DIV-1 and wraps to 0.
  - On the wrap, idx increments modulo 4 (3 → 0).
- State machine, two states derived per slot:
  - BLANK while div_cnt < BLANK_CYC.
  - SHOW while div_cnt >= BLANK_CYC.
  - Every slot is BLANK followed by SHOW. No other transitions exist.
- Frame boundary is the edge where div_cnt = DIV-1 and idx = 3. On that edge:
  - idx becomes 0.
  - i_sel_src, the selected 16-bit BCD, i_dot_mask and i_lzb_en are captured.
  - o_frame_start = 1 for exactly the following clock.
- Input changes between frame boundaries have no visible effect until the next boundary, including a source switch while idx = 1..2.
- Outputs are registered and lag the counter state by one clock:
  - In BLANK: o_fnd_com = 4'hF and o_fnd_data = 8'hFF.
  - In SHOW: o_fnd_com = ~(1 << idx) and o_fnd_data = {~dp[idx], seg(latched nibble idx)}.
- Segment decode, 7-bit active-low values:
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10.
  - Nibbles A–F show a dash, 3F (segment g only).
  - With dp off, the full bytes are 0 = C0 … 9 = 90, dash = BF.
- Leading-zero blanking, when latched lzb = 1:
  - Digit k (k = 3..1) is blanked (segments 7'h7F) if its nibble and every higher nibble are 0.
  - Digit 0 is never blanked.
  - dp is still honoured on a blanked digit.
  - The anode of a blanked digit is still driven in SHOW, so scan timing is unchanged.
- The first frame after reset shows the reset-latched data ("0000", dp off) until the first frame boundary.
- Reset asserted mid-slot returns everything to the reset state immediately. Scan restarts from digit 0 in BLANK.
- At most one anode is low in any cycle. No anode is low in the cycle after any slot change, because of the BLANK window.

Test Plan:
- Reset sequence. Use CLK_FREQ = 100, SCAN_HZ = 10 (DIV = 10) and BLANK_CYC = 2. Hold reset low, then release. Required: com = F and data = FF during reset; the first SHOW cycle is on clk 3 after release with com = E and data = C0; o_frame_start pulses 1 clock after the 40th clk.
- Scan order and timing. Set watch = 16'h1234, i_sel_src = 0, and run past the first frame boundary. Required per slot: 2 clocks of com = F, then 8 clocks of com = E/D/B/7 showing data = 99 / B0 / A4 / F9 (4, 3, 2, 1).
- Frame-atomic source switch. Set watch = 1234 and stopwatch = 5678, and toggle i_sel_src while idx = 1. Required: the remaining digits still show 2 and 1, and the next frame shows 8 (80), 7 (F8), 6 (82), 5 (92).
- Leading-zero blanking. Set BCD = 16'h0050, i_lzb_en = 1 and i_dot_mask = 4'b1000. Required:
  - digit0 = C0, digit1 = 92, digit2 = FF;
  - digit3 = 7F (blank with dp lit);
  - with i_lzb_en = 0, digits 2 and 3 show C0 and 40.
- Out-of-range BCD. Set a nibble to 4'hC. Required: that digit shows BF.
- Mid-scan reset. Assert reset during SHOW of idx = 2. Required: com = F immediately (asynchronous); after release the scan restarts at idx 0 in BLANK showing "0000".
